fft_frame_feeder: RTL and testbench
===================================

Name: fft_frame_feeder

Overview:
Synthesizable, parametrised sample-stream source for the delay-feedback FFT cores (fft_16 and wider successors).
- Host loads complex samples into an internal buffer of up to NFRM frames of NPT points each.
- On command, the block plays them out one sample per enabled cycle, in the sin_re/sin_im streaming format the FFT expects.
- Outputs carry frame markers, with optional continuous looping for throughput and soak runs.

Parameters:
WD, 12, sample width per component (signed two's complement)
NPT, 16, points per frame (power of 2, 4..1024)
NFRM, 4, frames of storage (power of 2, 1..64)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  global advance enable; 0 freezes playback pipeline
wr_en  in  1  write one sample this cycle
wr_re  in  WD  sample real part
wr_im  in  WD  sample imaginary part
wr_rdy  out  1  write accepted (IDLE and buffer not full)
clr  in  1  clear buffer contents count (IDLE only)
start  in  1  begin playback (pulse)
loop  in  1  sampled at start: 1 = repeat buffer until abort
abort  in  1  stop playback immediately
sout_re  out  WD  output sample real part, 0 when not valid
sout_im  out  WD  output sample imaginary part, 0 when not valid
sout_vld  out  1  output sample valid
sout_sof  out  1  first point of frame
sout_eof  out  1  last point of frame
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when non-loop playback completes
frm_cnt  out  16  frames emitted since start, saturating at 0xFFFF

Behaviour:
Reset values:
- All outputs 0 except wr_rdy=1.
- wr_ptr=0, state IDLE.

Write side:
- An accepted write (wr_en & wr_rdy) stores the sample at wr_ptr, then increments wr_ptr.
- Buffer full when wr_ptr==NPT*NFRM; wr_rdy=0 while full or state != IDLE.
- Unaccepted writes are dropped silently.
- clr in IDLE sets wr_ptr=0; clr is ignored outside IDLE. clr and wr_en in the same cycle: clr wins and the write is dropped.

Loaded frames:
- nfr = wr_ptr / NPT. The trailing partial frame is never played.

State machine (IDLE, PLAY, DRAIN):
- IDLE -> PLAY on start with nfr>=1. Capture loop, set rd_ptr=0, clear frm_cnt.
- start with nfr==0 is ignored and no done pulse is generated.
- PLAY: each cycle with en=1 issues a RAM read at rd_ptr, then rd_ptr++.
  - When rd_ptr reaches nfr*NPT-1: if loop=1, rd_ptr wraps to 0; else go to DRAIN.
- DRAIN: after the final sample leaves the output register (en=1), pulse done and return to IDLE.
- start in PLAY or DRAIN is ignored.

Latency and stall:
- Two-stage pipeline: RAM read register, then output register.
- With en held 1, the first sout_vld appears on the 2nd rising edge after the edge that sampled start.
- Output is continuous, one sample per cycle, including across frame boundaries and loop wrap.
- en=0 freezes rd_ptr, pipeline and outputs; nothing is lost or duplicated.

Markers:
- sout_sof=1 when the point index (rd_ptr mod NPT) of the emitted sample is 0.
- sout_eof=1 when that index is NPT-1.
- frm_cnt increments as each eof sample is emitted.

abort:
- Highest priority in any state.
- Next edge: state IDLE, pipeline flushed, sout_* = 0, no done pulse.
- wr_ptr and buffer contents are kept.

Reset mid-operation: asynchronous return to reset values; buffer RAM contents are undefined.

Optional Feature:
FEEDER_GAP_EN:
- Defined: adds input gap_len [7:0], sampled at start. After each eof sample, the block inserts gap_len cycles with sout_vld=0 and data 0 before the next sof. Gap cycles count only when en=1. gap_len=0 behaves exactly as the build without the feature.
- Undefined: port absent, frames are back-to-back.

Decomposition:
Package fft_feeder_pkg:
- state encoding localparams (IDLE, PLAY, DRAIN)
- DEPTH = NPT*NFRM
- AW = clog2(DEPTH)+1
- pointer width function
Sub-module feeder_buf:
- simple dual-port RAM, 2*WD wide, DEPTH deep
- registered read with read-enable tied to en

Test Plan:
- Reset, then write 16 samples re=i, im=-i (NPT=16) and pulse start with loop=0 -> 16 consecutive vld samples 0..15, sof on 0, eof on 15, frm_cnt=1, done pulses once, first vld 2 cycles after start.
- Write 40 samples and play -> exactly 32 samples emitted (2 frames), frm_cnt=2; samples 32..39 never appear.
- loop=1 with 1 frame, run 50 cycles, then abort -> pattern 0..15 repeats with sof every 16 cycles, no gap at wrap; after abort, sout_vld=0 and data 0 next cycle, no done pulse.
- en toggled 1,0,0,1 pseudo-randomly during play -> output sequence identical to the en=1 run, with outputs held while en=0.
- Fill to 64 samples, then attempt a 65th write and clr+wr_en together -> wr_rdy=0 at full, 65th dropped; clr wins, wr_ptr=0.
- FEEDER_GAP_EN with gap_len=3 and 2 frames -> 3 invalid zero cycles between eof of frame 0 and sof of frame 1.

Source files
------------

// File: rtl/fft_feeder_pkg.sv
// Shared definitions for the FFT frame feeder: state encoding and sizing helpers.
package fft_feeder_pkg;

  // Playback state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Total buffer depth in samples.
  function automatic int feeder_depth(input int npt, input int nfrm);
    return npt * nfrm;
  endfunction

  // Pointer width: one extra bit so a pointer can hold the value DEPTH (buffer full).
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/feeder_buf.sv
// Simple dual-port sample buffer with a registered read port.
// The read enable is driven by the global advance enable so the read register
// freezes together with the rest of the playback pipeline.
module feeder_buf #(
  parameter int DW    = 24,
  parameter int DEPTH = 64,
  parameter int ABW   = 6
) (
  input  logic           clk,
  input  logic           we,
  input  logic [ABW-1:0] waddr,
  input  logic [DW-1:0]  wdata,
  input  logic           re,
  input  logic [ABW-1:0] raddr,
  output logic [DW-1:0]  rdata
);

  logic [DW-1:0] mem [0:DEPTH-1];

  // Write port: store one sample per accepted write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered read, held while re is low.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Sample-stream source for the delay-feedback FFT cores.
// Host loads complex samples into a buffer of NFRM frames x NPT points, then
// plays whole frames out one sample per enabled cycle with sof/eof markers,
// optionally looping until abort.
// Optional build macro FEEDER_GAP_EN adds input gap_len: idle cycles inserted
// after every eof sample. Without the macro frames are back-to-back.
module fft_frame_feeder
  import fft_feeder_pkg::*;
#(
  parameter int WD   = 12,
  parameter int NPT  = 16,
  parameter int NFRM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          wr_en,
  input  logic [WD-1:0] wr_re,
  input  logic [WD-1:0] wr_im,
  output logic          wr_rdy,
  input  logic          clr,
  input  logic          start,
  input  logic          loop,
  input  logic          abort,
`ifdef FEEDER_GAP_EN
  input  logic [7:0]    gap_len,
`endif
  output logic [WD-1:0] sout_re,
  output logic [WD-1:0] sout_im,
  output logic          sout_vld,
  output logic          sout_sof,
  output logic          sout_eof,
  output logic          busy,
  output logic          done,
  output logic [15:0]   frm_cnt
);

  localparam int DEPTH = feeder_depth(NPT, NFRM);
  localparam int AW    = ptr_width(DEPTH);
  localparam int PW    = $clog2(NPT);

  logic [1:0]      state_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic            loop_reg;
  logic [7:0]      gap_reg;
  logic [7:0]      gap_cnt_reg;
  logic            s1_vld_reg;
  logic            s1_sof_reg;
  logic            s1_eof_reg;
  logic            done_reg;
  logic [WD-1:0]   sout_re_reg;
  logic [WD-1:0]   sout_im_reg;
  logic            sout_vld_reg;
  logic            sout_sof_reg;
  logic            sout_eof_reg;
  logic [15:0]     frm_cnt_reg;

  logic [7:0]      gap_in;
  logic            wr_acc;
  logic            nfr_zero;
  logic [AW-1:0]   play_len;
  logic [AW-1:0]   last_idx;
  logic [PW-1:0]   pt_idx;
  logic            start_go;
  logic [2*WD-1:0] rd_data;

`ifdef FEEDER_GAP_EN
  assign gap_in = gap_len;
`else
  assign gap_in = 8'd0;
`endif

  // Only whole frames are played: the trailing partial frame is masked off.
  assign play_len = {wr_ptr_reg[AW-1:PW], {PW{1'b0}}};
  assign last_idx = play_len - AW'(1);
  assign nfr_zero = (wr_ptr_reg[AW-1:PW] == '0);
  assign pt_idx   = rd_ptr_reg[PW-1:0];

  assign wr_rdy   = (state_reg == ST_IDLE) && (wr_ptr_reg != AW'(DEPTH));
  // clr takes precedence over a write in the same cycle (wr_rdy implies IDLE).
  assign wr_acc   = wr_en && wr_rdy && !clr;
  assign start_go = (state_reg == ST_IDLE) && start && !nfr_zero && !abort;

  feeder_buf #(
    .DW    (2*WD),
    .DEPTH (DEPTH),
    .ABW   (AW-1)
  ) u_buf (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_reg[AW-2:0]),
    .wdata ({wr_re, wr_im}),
    .re    (en),
    .raddr (rd_ptr_reg[AW-2:0]),
    .rdata (rd_data)
  );

  // Write pointer: advances per accepted write, cleared by clr while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
    end else if (clr && (state_reg == ST_IDLE)) begin
      wr_ptr_reg <= '0;
    end else if (wr_acc) begin
      wr_ptr_reg <= wr_ptr_reg + AW'(1);
    end
  end

  // Playback FSM and read stage: issues reads, tracks frame markers and gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      rd_ptr_reg  <= '0;
      loop_reg    <= 1'b0;
      gap_reg     <= '0;
      gap_cnt_reg <= '0;
      s1_vld_reg  <= 1'b0;
      s1_sof_reg  <= 1'b0;
      s1_eof_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        state_reg   <= ST_IDLE;
        gap_cnt_reg <= '0;
        s1_vld_reg  <= 1'b0;
        s1_sof_reg  <= 1'b0;
        s1_eof_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (en) begin
              s1_vld_reg <= 1'b0;
              s1_sof_reg <= 1'b0;
              s1_eof_reg <= 1'b0;
            end
            if (start_go) begin
              state_reg   <= ST_PLAY;
              loop_reg    <= loop;
              gap_reg     <= gap_in;
              gap_cnt_reg <= '0;
              rd_ptr_reg  <= '0;
            end
          end
          ST_PLAY: begin
            if (en) begin
              if (gap_cnt_reg != '0) begin
                // Inter-frame gap: hold rd_ptr and push a bubble down the pipe.
                gap_cnt_reg <= gap_cnt_reg - 8'd1;
                s1_vld_reg  <= 1'b0;
                s1_sof_reg  <= 1'b0;
                s1_eof_reg  <= 1'b0;
              end else begin
                s1_vld_reg <= 1'b1;
                s1_sof_reg <= (pt_idx == '0);
                s1_eof_reg <= (pt_idx == PW'(NPT-1));
                if (pt_idx == PW'(NPT-1)) gap_cnt_reg <= gap_reg;
                if (rd_ptr_reg == last_idx) begin
                  if (loop_reg) rd_ptr_reg <= '0;
                  else          state_reg  <= ST_DRAIN;
                end else begin
                  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
              end
            end
          end
          ST_DRAIN: begin
            if (en) begin
              s1_vld_reg <= 1'b0;
              s1_sof_reg <= 1'b0;
              s1_eof_reg <= 1'b0;
              // Read stage already empty: the final sample leaves the output now.
              if (!s1_vld_reg) begin
                state_reg <= ST_IDLE;
                done_reg  <= 1'b1;
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  // Output stage: zero data when not valid, count emitted frames on eof.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout_re_reg  <= '0;
      sout_im_reg  <= '0;
      sout_vld_reg <= 1'b0;
      sout_sof_reg <= 1'b0;
      sout_eof_reg <= 1'b0;
      frm_cnt_reg  <= '0;
    end else if (abort) begin
      sout_re_reg  <= '0;
      sout_im_reg  <= '0;
      sout_vld_reg <= 1'b0;
      sout_sof_reg <= 1'b0;
      sout_eof_reg <= 1'b0;
    end else begin
      if (start_go) frm_cnt_reg <= '0;
      if (en) begin
        sout_vld_reg <= s1_vld_reg;
        sout_sof_reg <= s1_vld_reg && s1_sof_reg;
        sout_eof_reg <= s1_vld_reg && s1_eof_reg;
        sout_re_reg  <= s1_vld_reg ? rd_data[2*WD-1:WD] : '0;
        sout_im_reg  <= s1_vld_reg ? rd_data[WD-1:0]    : '0;
        if (s1_vld_reg && s1_eof_reg && (frm_cnt_reg != 16'hFFFF))
          frm_cnt_reg <= frm_cnt_reg + 16'd1;
      end
    end
  end

  assign sout_re  = sout_re_reg;
  assign sout_im  = sout_im_reg;
  assign sout_vld = sout_vld_reg;
  assign sout_sof = sout_sof_reg;
  assign sout_eof = sout_eof_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign frm_cnt  = frm_cnt_reg;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed self-checking bench for fft_frame_feeder (WD=12, NPT=16, NFRM=4).
// Inputs change right after the falling edge; outputs are observed on the next
// falling edge, i.e. half a cycle after the rising edge that updated them.
module tb_fft_frame_feeder;

  localparam int WD   = 12;
  localparam int NPT  = 16;
  localparam int NFRM = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, wr_en, clr, start, loop, abort;
  logic [WD-1:0] wr_re, wr_im;
  logic          wr_rdy;
  logic [WD-1:0] sout_re, sout_im;
  logic          sout_vld, sout_sof, sout_eof, busy, done;
  logic [15:0]   frm_cnt;
`ifdef FEEDER_GAP_EN
  logic [7:0]    gap_len = 8'd0;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic          cap_vld  [0:99];
  logic [WD-1:0] cap_re   [0:99];
  logic [WD-1:0] cap_im   [0:99];
  logic          cap_sof  [0:99];
  logic          cap_eof  [0:99];
  logic          cap_done [0:99];
  logic          cap_busy [0:99];
  logic [15:0]   cap_frm  [0:99];

  fft_frame_feeder #(.WD(WD), .NPT(NPT), .NFRM(NFRM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .wr_en    (wr_en),
    .wr_re    (wr_re),
    .wr_im    (wr_im),
    .wr_rdy   (wr_rdy),
    .clr      (clr),
    .start    (start),
    .loop     (loop),
    .abort    (abort),
`ifdef FEEDER_GAP_EN
    .gap_len  (gap_len),
`endif
    .sout_re  (sout_re),
    .sout_im  (sout_im),
    .sout_vld (sout_vld),
    .sout_sof (sout_sof),
    .sout_eof (sout_eof),
    .busy     (busy),
    .done     (done),
    .frm_cnt  (frm_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_re = WD'(base + i);
      wr_im = WD'(0) - WD'(base + i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic do_clr;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Pulse start, then record n cycles of outputs (index 0 = first edge after start).
  task automatic play_capture(input logic lp, input int n);
    loop  = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
    loop  = 1'b0;
    for (int c = 0; c < n; c++) begin
      tick();
      cap_vld[c]  = sout_vld;
      cap_re[c]   = sout_re;
      cap_im[c]   = sout_im;
      cap_sof[c]  = sout_sof;
      cap_eof[c]  = sout_eof;
      cap_done[c] = done;
      cap_busy[c] = busy;
      cap_frm[c]  = frm_cnt;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; wr_en = 1'b0; clr = 1'b0; start = 1'b0;
    loop = 1'b0; abort = 1'b0; wr_re = '0; wr_im = '0;
    #12;
    total_cnt++;
    if ({sout_re, sout_im, sout_vld, sout_sof, sout_eof, busy, done, frm_cnt, wr_rdy} !==
        {{(2*WD+5+16){1'b0}}, 1'b1})
      $display("FAIL reset_values got re=%0d im=%0d vld=%b sof=%b eof=%b busy=%b done=%b frm=%0d rdy=%b want all 0, rdy=1",
               sout_re, sout_im, sout_vld, sout_sof, sout_eof, busy, done, frm_cnt, wr_rdy);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("test_reset: outputs idle, wr_rdy=%b", wr_rdy);
  endtask

  task automatic test_single_frame;
    int nv, first, ndone;
    logic [WD-1:0] e_re, e_im;
    do_clr();
    load(16, 0);
    play_capture(1'b0, 24);
    nv = 0; first = -1; ndone = 0;
    for (int c = 0; c < 24; c++) begin
      if (cap_done[c]) ndone++;
      if (cap_vld[c]) begin
        if (first < 0) first = c;
        e_re = WD'(nv);
        e_im = WD'(0) - e_re;
        total_cnt++;
        if ({cap_re[c], cap_im[c], cap_sof[c], cap_eof[c]} !== {e_re, e_im, (nv == 0), (nv == 15)})
          $display("FAIL single_sample%0d got re=%0d im=%0d sof=%b eof=%b want re=%0d im=%0d sof=%b eof=%b",
                   nv, cap_re[c], cap_im[c], cap_sof[c], cap_eof[c], e_re, e_im, (nv == 0), (nv == 15));
        else pass_cnt++;
        nv++;
      end
    end
    total_cnt++;
    if (first !== 1) $display("FAIL single_latency got first_vld_cycle=%0d want 1", first);
    else pass_cnt++;
    total_cnt++;
    if (nv !== 16) $display("FAIL single_count got %0d want 16", nv);
    else pass_cnt++;
    total_cnt++;
    if (ndone !== 1 || cap_done[17] !== 1'b1)
      $display("FAIL single_done got pulses=%0d at17=%b want 1 at cycle 17", ndone, cap_done[17]);
    else pass_cnt++;
    total_cnt++;
    if ({cap_frm[23], cap_busy[23]} !== {16'd1, 1'b0})
      $display("FAIL single_end got frm=%0d busy=%b want frm=1 busy=0", cap_frm[23], cap_busy[23]);
    else pass_cnt++;
    $display("test_single_frame: %0d samples, first at cycle %0d, frm_cnt=%0d", nv, first, cap_frm[23]);
  endtask

  task automatic test_partial_frame;
    int nv, ndone;
    logic [WD-1:0] e_re;
    do_clr();
    load(40, 0);
    play_capture(1'b0, 40);
    nv = 0; ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (cap_done[c]) ndone++;
      if (cap_vld[c]) begin
        e_re = WD'(nv);
        total_cnt++;
        if (cap_re[c] !== e_re) $display("FAIL partial_sample%0d got %0d want %0d", nv, cap_re[c], e_re);
        else pass_cnt++;
        nv++;
      end
    end
    total_cnt++;
    if ({nv, ndone} !== {32'd32, 32'd1}) $display("FAIL partial_count got samples=%0d done=%0d want 32 and 1", nv, ndone);
    else pass_cnt++;
    total_cnt++;
    if (cap_frm[39] !== 16'd2) $display("FAIL partial_frm got %0d want 2", cap_frm[39]);
    else pass_cnt++;
    $display("test_partial_frame: %0d samples from 40 loaded, frm_cnt=%0d", nv, cap_frm[39]);
  endtask

  task automatic test_loop_abort;
    logic          e_vld, e_sof;
    logic [WD-1:0] e_re;
    int            ndone;
    do_clr();
    load(16, 0);
    play_capture(1'b1, 50);
    for (int c = 0; c < 50; c++) begin
      e_vld = (c >= 1);
      e_re  = e_vld ? WD'((c - 1) % 16) : '0;
      e_sof = e_vld && ((c - 1) % 16 == 0);
      total_cnt++;
      if ({cap_vld[c], cap_re[c], cap_sof[c]} !== {e_vld, e_re, e_sof})
        $display("FAIL loop_cycle%0d got vld=%b re=%0d sof=%b want vld=%b re=%0d sof=%b",
                 c, cap_vld[c], cap_re[c], cap_sof[c], e_vld, e_re, e_sof);
      else pass_cnt++;
    end
    total_cnt++;
    if (cap_frm[49] !== 16'd3) $display("FAIL loop_frm got %0d want 3", cap_frm[49]);
    else pass_cnt++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++;
    if ({sout_vld, sout_re, sout_im, busy, done} !== {1'b0, {(2*WD){1'b0}}, 1'b0, 1'b0})
      $display("FAIL abort_flush got vld=%b re=%0d im=%0d busy=%b done=%b want all 0",
               sout_vld, sout_re, sout_im, busy, done);
    else pass_cnt++;
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done || sout_vld) ndone++;
    end
    total_cnt++;
    if ({ndone, wr_rdy} !== {32'd0, 1'b1})
      $display("FAIL abort_after got stray_events=%0d wr_rdy=%b want 0 and 1", ndone, wr_rdy);
    else pass_cnt++;
    $display("test_loop_abort: 49 looped samples, frm_cnt=%0d, aborted", cap_frm[49]);
  endtask

  // Expected outputs depend only on m, the number of enabled edges since start.
  task automatic test_en_stall;
    logic [15:0]   pat;
    int            m, cyc;
    logic          e_vld, e_done;
    logic [WD-1:0] e_re;
    logic [15:0]   e_frm;
    pat = 16'b1001_0110_1100_1011;
    do_clr();
    load(32, 0);
    en = 1'b1; loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    m = 0;
    for (cyc = 0; cyc < 200 && m < 36; cyc++) begin
      en = pat[cyc % 16];
      tick();
      if (en) m++;
      e_vld  = (m >= 2) && (m <= 33);
      e_re   = e_vld ? WD'(m - 2) : '0;
      e_done = en && (m == 34);
      e_frm  = (m >= 33) ? 16'd2 : (m >= 17) ? 16'd1 : 16'd0;
      total_cnt++;
      if ({sout_vld, sout_re, done, frm_cnt} !== {e_vld, e_re, e_done, e_frm})
        $display("FAIL stall_cycle%0d en=%b got vld=%b re=%0d done=%b frm=%0d want vld=%b re=%0d done=%b frm=%0d",
                 cyc, en, sout_vld, sout_re, done, frm_cnt, e_vld, e_re, e_done, e_frm);
      else pass_cnt++;
    end
    en = 1'b1;
    total_cnt++;
    if (m < 36) $display("FAIL stall_timeout got enabled_edges=%0d want 36", m);
    else pass_cnt++;
    $display("test_en_stall: %0d cycles with en pattern, %0d enabled", cyc, m);
  endtask

  task automatic test_full_clr;
    int nv, ndone;
    logic [WD-1:0] e_re;
    do_clr();
    load(64, 0);
    total_cnt++;
    if (wr_rdy !== 1'b0) $display("FAIL full_rdy got %b want 0", wr_rdy);
    else pass_cnt++;
    wr_en = 1'b1; wr_re = WD'(100); wr_im = WD'(0) - WD'(100);
    tick();
    wr_en = 1'b0;
    play_capture(1'b0, 70);
    nv = 0; ndone = 0;
    for (int c = 0; c < 70; c++) begin
      if (cap_done[c]) ndone++;
      if (cap_vld[c]) begin
        e_re = WD'(nv);
        total_cnt++;
        if (cap_re[c] !== e_re) $display("FAIL full_sample%0d got %0d want %0d", nv, cap_re[c], e_re);
        else pass_cnt++;
        nv++;
      end
    end
    total_cnt++;
    if ({nv, ndone, cap_frm[69]} !== {32'd64, 32'd1, 16'd4})
      $display("FAIL full_play got samples=%0d done=%0d frm=%0d want 64, 1, 4", nv, ndone, cap_frm[69]);
    else pass_cnt++;
    // clr together with a write: the write must be dropped.
    do_clr();
    load(5, 0);
    clr = 1'b1; wr_en = 1'b1; wr_re = WD'(77); wr_im = WD'(0) - WD'(77);
    tick();
    clr = 1'b0; wr_en = 1'b0;
    total_cnt++;
    if (wr_rdy !== 1'b1) $display("FAIL clr_rdy got %b want 1", wr_rdy);
    else pass_cnt++;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL empty_start got busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
    load(16, 200);
    play_capture(1'b0, 20);
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      if (cap_vld[c]) begin
        e_re = WD'(200 + nv);
        total_cnt++;
        if (cap_re[c] !== e_re) $display("FAIL clr_sample%0d got %0d want %0d", nv, cap_re[c], e_re);
        else pass_cnt++;
        nv++;
      end
    end
    total_cnt++;
    if (nv !== 16) $display("FAIL clr_count got %0d want 16", nv);
    else pass_cnt++;
    $display("test_full_clr: full at 64, refilled after clr, %0d samples replayed", nv);
  endtask

`ifdef FEEDER_GAP_EN
  task automatic test_gap;
    logic          e_vld, e_sof, e_eof;
    logic [WD-1:0] e_re;
    int            k, ndone;
    do_clr();
    load(32, 0);
    gap_len = 8'd3;
    play_capture(1'b0, 40);
    gap_len = 8'd0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (cap_done[c]) ndone++;
      if (c >= 1 && c <= 16)       k = c - 1;
      else if (c >= 20 && c <= 35) k = c - 4;
      else                         k = -1;
      e_vld = (k >= 0);
      e_re  = e_vld ? WD'(k) : '0;
      e_sof = e_vld && (k % 16 == 0);
      e_eof = e_vld && (k % 16 == 15);
      total_cnt++;
      if ({cap_vld[c], cap_re[c], cap_sof[c], cap_eof[c]} !== {e_vld, e_re, e_sof, e_eof})
        $display("FAIL gap_cycle%0d got vld=%b re=%0d sof=%b eof=%b want vld=%b re=%0d sof=%b eof=%b",
                 c, cap_vld[c], cap_re[c], cap_sof[c], cap_eof[c], e_vld, e_re, e_sof, e_eof);
      else pass_cnt++;
    end
    total_cnt++;
    if ({ndone, cap_done[36]} !== {32'd1, 1'b1}) $display("FAIL gap_done got pulses=%0d at36=%b want 1 at cycle 36", ndone, cap_done[36]);
    else pass_cnt++;
    $display("test_gap: 2 frames with gap_len=3");
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_partial_frame();
    test_loop_abort();
    test_en_stall();
    test_full_clr();
`ifdef FEEDER_GAP_EN
    test_gap();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
